// File: rtl/rgb_mode_ctrl.sv
// -----------------------------------------------------------------------------
// rgb_mode_ctrl
//
// Mode controller for the SPI-to-RGB LED path. Byte writes from the SPI
// command decoder land in shadow registers. A CTRL write with bit 7 set
// commits the shadow speed, colour, blink period and the written mode into
// the active registers in one step, then a phase-resync FSM holds the colour
// cycle generators at their start phase for SYNC_CYCLES clocks before
// enabling the selected mode.
//
// Ports:
//   i_clk         system clock
//   i_rst_n       asynchronous active-low reset
//   i_wr_stb      one-cycle register write strobe
//   i_wr_addr     write register address (0 CTRL, 1-3 speed, 4-6 RGB, 7 blink)
//   i_wr_data     write data byte
//   i_rd_addr     read register address
//   o_rd_data     registered read data (1-cycle latency)
//   o_speed       active speed divider value for the cycle generators
//   o_cycle_rst   holds the cycle generators at their start phase
//   o_rgb_sel     0 = cycle generators drive LEDs, 1 = static colour
//   o_static_rgb  active static colour {R,G,B}
//   o_led_en      LED output enable (0 forces all LEDs dark)
//   o_busy        high while the phase resync is in progress
// -----------------------------------------------------------------------------
module rgb_mode_ctrl #(
    parameter int          SYNC_CYCLES   = 4,
    parameter int          PRESCALE      = 65536,
    parameter logic [19:0] DEFAULT_SPEED = 20'h0FFFF
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_wr_stb,
    input  logic [2:0]  i_wr_addr,
    input  logic [7:0]  i_wr_data,
    input  logic [2:0]  i_rd_addr,
    output logic [7:0]  o_rd_data,
    output logic [19:0] o_speed,
    output logic        o_cycle_rst,
    output logic        o_rgb_sel,
    output logic [23:0] o_static_rgb,
    output logic        o_led_en,
    output logic        o_busy
);

    typedef enum logic [2:0] {
        S_OFF    = 3'd0,
        S_SYNC   = 3'd1,
        S_CYCLE  = 3'd2,
        S_STATIC = 3'd3,
        S_BLINK  = 3'd4
    } state_t;

    localparam int                SYNC_W     = (SYNC_CYCLES > 1) ? $clog2(SYNC_CYCLES) : 1;
    localparam logic [SYNC_W-1:0] SYNC_LAST  = SYNC_W'(SYNC_CYCLES - 1);
    localparam logic [31:0]       PRESC_LAST = 32'(PRESCALE - 1);

    // Maps a CTRL mode field to the FSM state that serves it.
    function automatic state_t mode_to_state(input logic [1:0] mode);
        state_t st;
        case (mode)
            2'd0:    st = S_OFF;
            2'd1:    st = S_CYCLE;
            2'd2:    st = S_STATIC;
            2'd3:    st = S_BLINK;
            default: st = S_OFF;
        endcase
        return st;
    endfunction

    // Shadow registers (software view)
    logic [1:0]  sh_mode_r;
    logic [19:0] sh_speed_r;
    logic [7:0]  sh_red_r;
    logic [7:0]  sh_green_r;
    logic [7:0]  sh_blue_r;
    logic [7:0]  sh_half_r;

    // Active registers (hardware view, loaded only on commit)
    logic [1:0]  act_mode_r;
    logic [19:0] act_speed_r;
    logic [23:0] act_rgb_r;
    logic [7:0]  act_half_r;

    // FSM and counters
    state_t            state_r;
    state_t            state_nxt_s;
    logic [SYNC_W-1:0] sync_cnt_r;
    logic [SYNC_W-1:0] sync_cnt_nxt_s;
    logic [31:0]       presc_cnt_r;
    logic [7:0]        half_cnt_r;
    logic [7:0]        half_last_s;
    logic              blink_led_r;

    // Next values of the registered outputs
    logic              cycle_rst_nxt_s;
    logic              rgb_sel_nxt_s;
    logic              led_en_nxt_s;
    logic              busy_nxt_s;
    logic [7:0]        rd_nxt_s;

    logic              commit_s;

    assign commit_s = i_wr_stb && (i_wr_addr == 3'd0) && i_wr_data[7];

    // Shadow register file: every byte write lands here, including CTRL.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            sh_mode_r  <= 2'd0;
            sh_speed_r <= DEFAULT_SPEED;
            sh_red_r   <= 8'd0;
            sh_green_r <= 8'd0;
            sh_blue_r  <= 8'd0;
            sh_half_r  <= 8'd1;
        end else if (i_wr_stb) begin
            case (i_wr_addr)
                3'd0:    sh_mode_r          <= i_wr_data[1:0];
                3'd1:    sh_speed_r[7:0]    <= i_wr_data;
                3'd2:    sh_speed_r[15:8]   <= i_wr_data;
                3'd3:    sh_speed_r[19:16]  <= i_wr_data[3:0];
                3'd4:    sh_red_r           <= i_wr_data;
                3'd5:    sh_green_r         <= i_wr_data;
                3'd6:    sh_blue_r          <= i_wr_data;
                3'd7:    sh_half_r          <= i_wr_data;
                default: sh_mode_r          <= sh_mode_r;
            endcase
        end
    end

    // Active register set: loaded atomically on commit. The mode comes from
    // the commit byte itself, not from the shadow mode.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            act_mode_r  <= 2'd0;
            act_speed_r <= DEFAULT_SPEED;
            act_rgb_r   <= 24'd0;
            act_half_r  <= 8'd1;
        end else if (commit_s) begin
            act_mode_r  <= i_wr_data[1:0];
            act_speed_r <= sh_speed_r;
            act_rgb_r   <= {sh_red_r, sh_green_r, sh_blue_r};
            act_half_r  <= sh_half_r;
        end
    end

    // FSM state and sync counter register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_r    <= S_OFF;
            sync_cnt_r <= '0;
        end else begin
            state_r    <= state_nxt_s;
            sync_cnt_r <= sync_cnt_nxt_s;
        end
    end

    // Next-state logic and next values of the state-derived outputs.
    // Outputs follow state_r one clock later, so a commit at edge k shows
    // its resync outputs after k+1 and its target-mode outputs after
    // k+1+SYNC_CYCLES.
    always_comb begin
        state_nxt_s     = state_r;
        sync_cnt_nxt_s  = '0;
        cycle_rst_nxt_s = 1'b1;
        rgb_sel_nxt_s   = 1'b0;
        led_en_nxt_s    = 1'b0;
        busy_nxt_s      = 1'b0;

        if (commit_s) begin
            state_nxt_s    = S_SYNC;
            sync_cnt_nxt_s = '0;
        end else if (state_r == S_SYNC) begin
            if (sync_cnt_r == SYNC_LAST) begin
                state_nxt_s    = mode_to_state(act_mode_r);
                sync_cnt_nxt_s = '0;
            end else begin
                state_nxt_s    = S_SYNC;
                sync_cnt_nxt_s = sync_cnt_r + {{(SYNC_W-1){1'b0}}, 1'b1};
            end
        end else begin
            state_nxt_s    = state_r;
            sync_cnt_nxt_s = '0;
        end

        case (state_r)
            S_OFF: begin
                cycle_rst_nxt_s = 1'b1;
                rgb_sel_nxt_s   = 1'b0;
                led_en_nxt_s    = 1'b0;
            end
            S_SYNC: begin
                cycle_rst_nxt_s = 1'b1;
                led_en_nxt_s    = 1'b0;
                busy_nxt_s      = 1'b1;
            end
            S_CYCLE: begin
                cycle_rst_nxt_s = 1'b0;
                rgb_sel_nxt_s   = 1'b0;
                led_en_nxt_s    = 1'b1;
            end
            S_STATIC: begin
                cycle_rst_nxt_s = 1'b1;
                rgb_sel_nxt_s   = 1'b1;
                led_en_nxt_s    = 1'b1;
            end
            S_BLINK: begin
                cycle_rst_nxt_s = 1'b1;
                rgb_sel_nxt_s   = 1'b1;
                led_en_nxt_s    = blink_led_r;
            end
            default: begin
                cycle_rst_nxt_s = 1'b1;
                rgb_sel_nxt_s   = 1'b0;
                led_en_nxt_s    = 1'b0;
            end
        endcase
    end

    // A half-period of 0 behaves like 1; the toggle fires on the last unit.
    assign half_last_s = (act_half_r == 8'd0) ? 8'd0 : (act_half_r - 8'd1);

    // Blink timebase: idles cleared (LED phase on) outside S_BLINK so every
    // entry, and every commit, restarts a full on-phase.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            presc_cnt_r <= 32'd0;
            half_cnt_r  <= 8'd0;
            blink_led_r <= 1'b1;
        end else if (commit_s || (state_r != S_BLINK)) begin
            presc_cnt_r <= 32'd0;
            half_cnt_r  <= 8'd0;
            blink_led_r <= 1'b1;
        end else if (presc_cnt_r == PRESC_LAST) begin
            presc_cnt_r <= 32'd0;
            if (half_cnt_r == half_last_s) begin
                half_cnt_r  <= 8'd0;
                blink_led_r <= ~blink_led_r;
            end else begin
                half_cnt_r  <= half_cnt_r + 8'd1;
            end
        end else begin
            presc_cnt_r <= presc_cnt_r + 32'd1;
        end
    end

    // Read mux: address 0 is live status, the rest are shadow values.
    always_comb begin
        rd_nxt_s = 8'd0;
        case (i_rd_addr)
            3'd0:    rd_nxt_s = {o_busy, 5'd0, act_mode_r};
            3'd1:    rd_nxt_s = sh_speed_r[7:0];
            3'd2:    rd_nxt_s = sh_speed_r[15:8];
            3'd3:    rd_nxt_s = {4'd0, sh_speed_r[19:16]};
            3'd4:    rd_nxt_s = sh_red_r;
            3'd5:    rd_nxt_s = sh_green_r;
            3'd6:    rd_nxt_s = sh_blue_r;
            3'd7:    rd_nxt_s = sh_half_r;
            default: rd_nxt_s = 8'd0;
        endcase
    end

    // Output register stage.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_rd_data    <= 8'd0;
            o_speed      <= DEFAULT_SPEED;
            o_static_rgb <= 24'd0;
            o_cycle_rst  <= 1'b1;
            o_rgb_sel    <= 1'b0;
            o_led_en     <= 1'b0;
            o_busy       <= 1'b0;
        end else begin
            o_rd_data    <= rd_nxt_s;
            o_speed      <= act_speed_r;
            o_static_rgb <= act_rgb_r;
            o_cycle_rst  <= cycle_rst_nxt_s;
            o_rgb_sel    <= rgb_sel_nxt_s;
            o_led_en     <= led_en_nxt_s;
            o_busy       <= busy_nxt_s;
        end
    end

endmodule
